// File: rtl/dtw_pkg.sv
// -----------------------------------------------------------------------------
// dtw_pkg
// Shared codes for the DTW memory sequencer.
//   dtw_state_e : FSM state codes as seen on dtw_state
//   dtw_mode_e  : host mode codes carried on sys_status
// -----------------------------------------------------------------------------
package dtw_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_TEMP = 4'd1,
    ST_LOAD_TEST = 4'd2,
    ST_COMPUTE   = 4'd3,
    ST_DONE      = 4'd4
  } dtw_state_e;

  typedef enum logic [1:0] {
    MODE_IDLE      = 2'b00,
    MODE_LOAD_TEMP = 2'b01,
    MODE_LOAD_TEST = 2'b10,
    MODE_COMPUTE   = 2'b11
  } dtw_mode_e;

endpackage

// File: rtl/dtw_mem_sequencer_if.sv
// -----------------------------------------------------------------------------
// dtw_mem_sequencer_if
// Host/memory bundle for the DTW memory sequencer.
//   host -> seq : en, sys_status, data_addr, data_wr, temp_len, test_len
//   seq -> mems : temp/test sample addresses, even/odd row-buffer addresses
//                 (a: write/read, b: read only), four write enables
//   seq -> host : dtw_state, busy, done
// The master modport is the host side; the slave modport is the sequencer.
// -----------------------------------------------------------------------------
interface dtw_mem_sequencer_if #(
  parameter int ADDR_W = 8
);

  logic              en;
  logic [1:0]        sys_status;
  logic [ADDR_W-1:0] data_addr;
  logic              data_wr;
  logic [ADDR_W-1:0] temp_len;
  logic [ADDR_W-1:0] test_len;

  logic [3:0]        dtw_state;
  logic [ADDR_W-1:0] temp_mem_addr;
  logic [ADDR_W-1:0] test_mem_addr;
  logic [ADDR_W-1:0] even_addra;
  logic [ADDR_W-1:0] even_addrb;
  logic [ADDR_W-1:0] odd_addra;
  logic [ADDR_W-1:0] odd_addrb;
  logic              temp_mem_write_enable;
  logic              test_mem_write_enable;
  logic              even_mem_write_enable;
  logic              odd_mem_write_enable;
  logic              busy;
  logic              done;

  modport master (
    output en, sys_status, data_addr, data_wr, temp_len, test_len,
    input  dtw_state, temp_mem_addr, test_mem_addr,
           even_addra, even_addrb, odd_addra, odd_addrb,
           temp_mem_write_enable, test_mem_write_enable,
           even_mem_write_enable, odd_mem_write_enable,
           busy, done
  );

  modport slave (
    input  en, sys_status, data_addr, data_wr, temp_len, test_len,
    output dtw_state, temp_mem_addr, test_mem_addr,
           even_addra, even_addrb, odd_addra, odd_addrb,
           temp_mem_write_enable, test_mem_write_enable,
           even_mem_write_enable, odd_mem_write_enable,
           busy, done
  );

endinterface

// File: rtl/dtw_idx_counter.sv
// -----------------------------------------------------------------------------
// dtw_idx_counter
// Nested row/column counter for the DTW cost matrix walk.
//   clk, rst      : clock, synchronous active-high reset
//   i_clear       : latch the two lengths and zero i/j
//   i_adv         : advance one cell (j fastest, wraps into i)
//   i_temp_len    : template length minus one (column limit)
//   i_test_len    : test length minus one (row limit)
//   o_i, o_j      : current row / column
//   o_last        : current cell is the final cell of the matrix
// -----------------------------------------------------------------------------
module dtw_idx_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_adv,
  input  logic [ADDR_W-1:0] i_temp_len,
  input  logic [ADDR_W-1:0] i_test_len,
  output logic [ADDR_W-1:0] o_i,
  output logic [ADDR_W-1:0] o_j,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_temp_len;
  logic [ADDR_W-1:0] r_test_len;
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic              w_row_end;

  assign w_row_end = (r_j == r_temp_len);
  assign o_last    = w_row_end && (r_i == r_test_len);
  assign o_i       = r_i;
  assign o_j       = r_j;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_temp_len <= '0;
      r_test_len <= '0;
      r_i        <= '0;
      r_j        <= '0;
    end else if (i_clear) begin
      r_temp_len <= i_temp_len;
      r_test_len <= i_test_len;
      r_i        <= '0;
      r_j        <= '0;
    end else if (i_adv && !o_last) begin
      // The final cell holds its indices; the FSM leaves COMPUTE on it.
      if (w_row_end) begin
        r_j <= '0;
        r_i <= r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtw_mem_sequencer.sv
// -----------------------------------------------------------------------------
// dtw_mem_sequencer
// Address/write-enable sequencer for a DTW engine: routes host sample writes
// into the template and test memories, then walks the cost matrix row by
// row, ping-ponging between an even and an odd row buffer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dtw_mem_sequencer_if slave (host controls, memory addresses,
//              write enables, dtw_state/busy/done)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE (0)   | nothing active; waits for a mode on sys_status
// LOAD_TEMP  | host writes template samples through data_addr/data_wr
// LOAD_TEST  | host writes test samples through data_addr/data_wr
// COMPUTE    | one matrix cell per en cycle, row-major
// DONE (4)   | one-cycle done pulse, then IDLE
// -----------------------------------------------------------------------------
module dtw_mem_sequencer
  import dtw_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 2 ** ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  dtw_mem_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(MAX_LEN - 1);

  dtw_state_e        r_state;
  dtw_state_e        w_state_nxt;
  logic              r_cmp_block;
  logic              w_cnt_clear;
  logic              w_cnt_adv;
  logic [ADDR_W-1:0] w_i;
  logic [ADDR_W-1:0] w_j;
  logic [ADDR_W-1:0] w_j_prev;
  logic              w_last;
  logic [ADDR_W-1:0] w_temp_len;
  logic [ADDR_W-1:0] w_test_len;

  // Lengths beyond the supported series size are clamped to it.
  assign w_temp_len = (bus.temp_len > LEN_MAX) ? LEN_MAX : bus.temp_len;
  assign w_test_len = (bus.test_len > LEN_MAX) ? LEN_MAX : bus.test_len;

  // Left/diagonal neighbour column; column 0 has none, so read cell 0.
  assign w_j_prev = (w_j == '0) ? '0 : (w_j - 1'b1);

  dtw_idx_counter #(
    .ADDR_W (ADDR_W)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_cnt_clear),
    .i_adv      (w_cnt_adv),
    .i_temp_len (w_temp_len),
    .i_test_len (w_test_len),
    .o_i        (w_i),
    .o_j        (w_j),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // After a completed compute, a held 11 must not retrigger: block until
  // sys_status shows some other mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp_block <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_cmp_block <= 1'b1;
    end else if (bus.sys_status != MODE_COMPUTE) begin
      r_cmp_block <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clear = 1'b0;
    w_cnt_adv   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (bus.sys_status)
          MODE_LOAD_TEMP: w_state_nxt = ST_LOAD_TEMP;
          MODE_LOAD_TEST: w_state_nxt = ST_LOAD_TEST;
          MODE_COMPUTE: begin
            if (!r_cmp_block) begin
              w_state_nxt = ST_COMPUTE;
              w_cnt_clear = 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
      ST_LOAD_TEMP: begin
        if (bus.sys_status != MODE_LOAD_TEMP) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD_TEST: begin
        if (bus.sys_status != MODE_LOAD_TEST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (bus.sys_status != MODE_COMPUTE) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.en) begin
          w_cnt_adv = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.dtw_state             = 4'd0;
    bus.temp_mem_addr         = '0;
    bus.test_mem_addr         = '0;
    bus.even_addra            = '0;
    bus.even_addrb            = '0;
    bus.odd_addra             = '0;
    bus.odd_addrb             = '0;
    bus.temp_mem_write_enable = 1'b0;
    bus.test_mem_write_enable = 1'b0;
    bus.even_mem_write_enable = 1'b0;
    bus.odd_mem_write_enable  = 1'b0;
    bus.busy                  = 1'b0;
    bus.done                  = 1'b0;
    if (!rst) begin
      bus.dtw_state = r_state;
      bus.busy      = (r_state != ST_IDLE);
      case (r_state)
        ST_LOAD_TEMP: begin
          bus.temp_mem_addr         = bus.data_addr;
          bus.temp_mem_write_enable = bus.data_wr & bus.en;
        end
        ST_LOAD_TEST: begin
          bus.test_mem_addr         = bus.data_addr;
          bus.test_mem_write_enable = bus.data_wr & bus.en;
        end
        ST_COMPUTE: begin
          bus.temp_mem_addr = w_j;
          bus.test_mem_addr = w_i;
          // Both row buffers see the same column addresses; only the write
          // enable distinguishes the current row from the previous one.
          bus.even_addra    = w_j;
          bus.even_addrb    = w_j_prev;
          bus.odd_addra     = w_j;
          bus.odd_addrb     = w_j_prev;
          bus.even_mem_write_enable = bus.en & ~w_i[0];
          bus.odd_mem_write_enable  = bus.en &  w_i[0];
        end
        ST_DONE: bus.done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dtw_mem_sequencer
// Drives the sequencer through loads, full computes, enable gaps, aborts and
// resets, and compares every output each cycle against a cell-list model.
// -----------------------------------------------------------------------------
module tb_dtw_mem_sequencer;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  dtw_mem_sequencer_if #(.ADDR_W(AW)) bus ();

  dtw_mem_sequencer #(
    .ADDR_W  (AW),
    .MAX_LEN (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // {state, temp, test, ea, eb, oa, ob, we{temp,test,even,odd}, busy, done}
  logic [57:0] obs;
  assign obs = {bus.dtw_state, bus.temp_mem_addr, bus.test_mem_addr,
                bus.even_addra, bus.even_addrb, bus.odd_addra, bus.odd_addrb,
                bus.temp_mem_write_enable, bus.test_mem_write_enable,
                bus.even_mem_write_enable, bus.odd_mem_write_enable,
                bus.busy, bus.done};

  function automatic logic [57:0] pack(input logic [3:0] st,
                                       input logic [AW-1:0] ta, sa, ea, eb, oa, ob,
                                       input logic [3:0] we,
                                       input logic b, d);
    return {st, ta, sa, ea, eb, oa, ob, we, b, d};
  endfunction

  logic [57:0] expv;
  localparam logic [57:0] ZERO_V = '0;

  // kind: 0 complete, 1 sys_status abort at (ai,aj), 2 reset at (ai,aj)
  // en_mode: 0 always on, 1 random, 2 one gap on the third cycle
  task automatic run_compute(input int tl, input int sl, input int en_mode,
                             input int kind, input int ai, input int aj,
                             input bit keep_status, input string nm);
    int ci, cj, writes, cyc;
    bit e, stopped;
    logic [AW-1:0] pj;
    ci = 0; cj = 0; writes = 0; cyc = 0; stopped = 0;
    @(negedge clk);
    bus.sys_status = 2'b11;
    bus.temp_len   = AW'(tl);
    bus.test_len   = AW'(sl);
    bus.en         = 1'b1;
    while (ci <= sl && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      // lengths are latched at entry; later changes must be ignored
      bus.temp_len  = AW'($urandom);
      bus.test_len  = AW'($urandom);
      bus.data_wr   = 1'($urandom);
      bus.data_addr = AW'($urandom);
      if (kind != 0 && ci == ai && cj == aj) begin
        stopped = 1;
        if (kind == 1) begin
          bus.en = 1'b0;
          bus.sys_status = 2'b00;
          #1;
          tests_run++;
          expv = pack(4'd3, AW'(cj), AW'(ci), AW'(cj), (cj == 0) ? AW'(0) : AW'(cj - 1),
                      AW'(cj), (cj == 0) ? AW'(0) : AW'(cj - 1), 4'b0000, 1'b1, 1'b0);
          if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s abort_cycle got=%h want=%h", nm, obs, expv);
          end
        end else begin
          bus.en = 1'b1;
          rst = 1'b1;
        end
        break;
      end
      case (en_mode)
        0: e = 1'b1;
        1: e = ($urandom_range(0, 2) != 0);
        default: e = (cyc != 3);
      endcase
      bus.en = e;
      #1;
      pj = (cj == 0) ? AW'(0) : AW'(cj - 1);
      expv = pack(4'd3, AW'(cj), AW'(ci), AW'(cj), pj, AW'(cj), pj,
                  {2'b00, e && (ci % 2 == 0), e && (ci % 2 == 1)}, 1'b1, 1'b0);
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL %s cell i=%0d j=%0d en=%0d got=%h want=%h", nm, ci, cj, e, obs, expv);
      end
      if (e) begin
        writes++;
        if (cj == tl) begin cj = 0; ci++; end
        else cj++;
      end
    end
    if (cyc >= 3000) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout cycles=%0d required<3000", nm, cyc);
    end
    if (stopped) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (obs !== ZERO_V) begin
        tests_failed++;
        $display("FAIL %s after_stop got=%h want=%h", nm, obs, ZERO_V);
      end
      rst = 1'b0;
      bus.sys_status = 2'b00;
      bus.data_wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #1;
        tests_run++;
        if (obs !== ZERO_V) begin
          tests_failed++;
          $display("FAIL %s idle_after_stop k=%0d got=%h want=%h", nm, k, obs, ZERO_V);
        end
      end
    end else begin
      tests_run++;
      if (writes != (tl + 1) * (sl + 1)) begin
        tests_failed++;
        $display("FAIL %s write_count got=%0d want=%0d", nm, writes, (tl + 1) * (sl + 1));
      end
      @(negedge clk);
      bus.en = 1'($urandom);
      #1;
      tests_run++;
      expv = pack(4'd4, '0, '0, '0, '0, '0, '0, 4'b0000, 1'b1, 1'b1);
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL %s done_cycle got=%h want=%h", nm, obs, expv);
      end
      if (!keep_status) bus.sys_status = 2'b00;
      bus.data_wr = 1'b0;
      @(negedge clk);
      #1;
      tests_run++;
      if (obs !== ZERO_V) begin
        tests_failed++;
        $display("FAIL %s after_done got=%h want=%h", nm, obs, ZERO_V);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.sys_status = 2'b11; bus.data_wr = 1'b1;
    bus.data_addr = 8'h5a; bus.temp_len = 8'd3; bus.test_len = 8'd3;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (obs !== ZERO_V) begin
      tests_failed++;
      $display("FAIL reset_state got=%h want=%h", obs, ZERO_V);
    end
    bus.sys_status = 2'b00;
    bus.data_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [AW-1:0] a;
    logic w, e;
    @(negedge clk);
    bus.sys_status = 2'b01; bus.en = 1'b1; bus.data_wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.data_addr = AW'(k); bus.data_wr = 1'b1;
      #1;
      tests_run++;
      expv = pack(4'd1, AW'(k), '0, '0, '0, '0, '0, 4'b1000, 1'b1, 1'b0);
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL load_temp_seq k=%0d got=%h want=%h", k, obs, expv);
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a = AW'($urandom); w = 1'($urandom); e = 1'($urandom);
      bus.data_addr = a; bus.data_wr = w; bus.en = e;
      #1;
      tests_run++;
      expv = pack(4'd1, a, '0, '0, '0, '0, '0, {w & e, 3'b000}, 1'b1, 1'b0);
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL load_temp_rand k=%0d got=%h want=%h", k, obs, expv);
      end
    end
    @(negedge clk);
    bus.sys_status = 2'b10; bus.data_wr = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (obs !== ZERO_V) begin
      tests_failed++;
      $display("FAIL load_to_load_idle got=%h want=%h", obs, ZERO_V);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a = AW'($urandom); w = 1'($urandom); e = 1'($urandom);
      bus.data_addr = a; bus.data_wr = w; bus.en = e;
      #1;
      tests_run++;
      expv = pack(4'd2, '0, a, '0, '0, '0, '0, {1'b0, w & e, 2'b00}, 1'b1, 1'b0);
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL load_test_rand k=%0d got=%h want=%h", k, obs, expv);
      end
    end
    @(negedge clk);
    bus.sys_status = 2'b00; bus.data_wr = 1'b0; bus.en = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (obs !== ZERO_V) begin
      tests_failed++;
      $display("FAIL load_exit_idle got=%h want=%h", obs, ZERO_V);
    end
  endtask

  task automatic test_no_restart();
    run_compute(1, 1, 0, 0, 0, 0, 1'b1, "hold11");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (obs !== ZERO_V) begin
        tests_failed++;
        $display("FAIL no_restart k=%0d got=%h want=%h", k, obs, ZERO_V);
      end
    end
    @(negedge clk);
    bus.sys_status = 2'b00;
    run_compute(2, 1, 0, 0, 0, 0, 1'b0, "rearm");
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      run_compute($urandom_range(0, 6), $urandom_range(0, 5), 1, 0, 0, 0, 1'b0, "random");
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.sys_status = 2'b00; bus.data_addr = '0; bus.data_wr = 1'b0;
    bus.temp_len = '0; bus.test_len = '0;
    test_reset();
    test_load();
    run_compute(3, 2, 0, 0, 0, 0, 1'b0, "basic_3x2");
    run_compute(3, 2, 2, 0, 0, 0, 1'b0, "en_gap");
    run_compute(3, 3, 0, 1, 1, 1, 1'b0, "abort_11");
    run_compute(0, 0, 0, 0, 0, 0, 1'b0, "one_cell");
    run_compute(7, 4, 0, 2, 2, 5, 1'b0, "reset_mid");
    test_no_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time_limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dtw_mem_sequencer.md
DTW_MEM_SEQUENCER -- requirements
Module: dtw_mem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address width of all memories.
REQ-002 SHALL have parameter MAX_LEN, default 2**ADDR_W, meaning the largest supported series length.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: advance enable; en=0 freezes all counters and forces every write enable low.
REQ-006 SHALL have port sys_status, input, 2 bits, meaning the mode: 00 idle, 01 load template, 10 load test, 11 compute.
REQ-007 SHALL have port data_addr, input, ADDR_W bits: host sample address during load modes.
REQ-008 SHALL have port data_wr, input, 1 bit: host sample write strobe.
REQ-009 SHALL have ports temp_len and test_len, input, ADDR_W bits each: series length minus one, sampled at compute entry.
REQ-010 SHALL have port dtw_state, output, 4 bits: current FSM state code.
REQ-011 SHALL have ports temp_mem_addr and test_mem_addr, output, ADDR_W bits each.
REQ-012 SHALL have ports even_addra, even_addrb, odd_addra and odd_addrb, output, ADDR_W bits each: row-buffer ports; port a writes/reads, port b reads only.
REQ-013 SHALL have ports temp_mem_write_enable, test_mem_write_enable, even_mem_write_enable and odd_mem_write_enable, output, 1 bit each.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on compute completion.

Function
REQ-016 SHALL implement the following states and codes: IDLE=0, LOAD_TEMP=1, LOAD_TEST=2, COMPUTE=3, DONE=4.
REQ-017 SHALL take these transitions from IDLE: sys_status 01 -> LOAD_TEMP; 10 -> LOAD_TEST; 11 -> COMPUTE, latching temp_len and test_len and clearing i and j.
REQ-018 SHALL, from LOAD_TEMP or LOAD_TEST, return to IDLE when sys_status leaves that state's mode; a direct load-to-load or load-to-compute change passes through IDLE for one cycle.
REQ-019 SHALL, in LOAD_TEMP, drive temp_mem_addr = data_addr and temp_mem_write_enable = data_wr & en, combinationally.
REQ-020 SHALL, in LOAD_TEST, drive test_mem_addr = data_addr and test_mem_write_enable = data_wr & en, combinationally.
REQ-021 SHALL, in COMPUTE, use row counter i (over test samples) and column counter j (over template samples): temp_mem_addr = j, test_mem_addr = i, both registered.
REQ-022 SHALL, in COMPUTE, use current-row buffer even when i[0]=0 and odd otherwise: current addra = j (write D[i][j]); current addrb = j-1, clamped to 0 when j=0 (left cell); previous addra = j (up cell); previous addrb = j-1, clamped to 0 when j=0 (diagonal cell).
REQ-023 SHALL, in COMPUTE, assert the current-row write enable when en=1 and hold the previous-row write enable low.
REQ-024 SHALL advance j by 1 per en cycle; when j = latched temp_len, j wraps to 0 and i increments.
REQ-025 SHALL, when i = test_len and j = temp_len with en=1, perform that final write, then go to DONE.
REQ-026 SHALL, in DONE, pulse done high for exactly one cycle, then go to IDLE regardless of sys_status.
REQ-027 SHALL treat temp_len = test_len = 0 as a one-cell compute: a single write to even[0], then DONE.
REQ-028 SHALL, when sys_status leaves 11 mid-compute, abort to IDLE next cycle with no done pulse and all write enables low.
REQ-029 SHALL not restart from IDLE while sys_status stays 11 after DONE; a new compute requires sys_status to pass through another value.
REQ-030 SHALL hold every non-active address at 0 and every non-active write enable at 0 in all states.

Reset
REQ-031 SHALL, while rst=1, set the state to IDLE, i, j and the latched lengths to 0, all addresses to 0, all write enables to 0, and busy and done to 0, taking precedence over en.

Structure
REQ-032 SHALL place the state codes and sys_status mode codes in a shared package dtw_pkg.
REQ-033 SHALL implement the i/j nested counter with wrap, enable and terminal flag as sub-module dtw_idx_counter, parameterised by ADDR_W.

Verification
REQ-034 SHALL cover: rst during COMPUTE at i=2, j=5 -> next cycle dtw_state=0, all addresses 0, all write enables 0.
REQ-035 SHALL cover: LOAD_TEMP with data_addr 0..7 and data_wr=1 -> temp_mem_write_enable high 8 cycles, temp_mem_addr tracks data_addr.
REQ-036 SHALL cover: temp_len=3, test_len=2 -> 12 writes alternating even/odd rows (i=0: even addra 0..3; i=1: odd addra 0..3; i=2: even) and done one cycle after the last write.
REQ-037 SHALL cover: en toggled 1,0,1 mid-row -> j held and write enables low on the en=0 cycle; the total write count is unchanged.
REQ-038 SHALL cover: sys_status 11 -> 00 at i=1, j=1 -> IDLE with no done pulse.
REQ-039 SHALL cover: temp_len = test_len = 0 -> one even write at address 0, done pulse, busy low afterwards.
